// File: rtl/gerenciador_estados.sv
// Pet state controller: evaluates buttons and status meters once per tick and
// drives the one-hot pet state, alert mask and a soft restart on a long double hold.
module gerenciador_estados #(
    parameter int N_ST         = 3,
    parameter int W            = 8,
    parameter int TICK_PERIOD  = 4194304,
    parameter int ALERT_LVL    = 32,
    parameter int ACTION_TICKS = 8,
    parameter int HOLD_CYCLES  = 16777216
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b1,
    input  logic              b2,
    input  logic              b1_hold,
    input  logic              b2_hold,
    input  logic [N_ST*W-1:0] status,
    output logic [5:0]        estado,
    output logic              tick,
    output logic [N_ST-1:0]   alerta
);

    typedef enum logic [5:0] {
        INTRO      = 6'b000000,
        IDLE       = 6'b000001,
        DORMINDO   = 6'b000010,
        COMENDO    = 6'b000100,
        DANDO_AULA = 6'b001000,
        MORTO      = 6'b010000,
        ALERTA     = 6'b100000
    } estado_t;

    localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int AW = (ACTION_TICKS > 0) ? $clog2(ACTION_TICKS + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0] ACT_MAX   = AW'(ACTION_TICKS);
    localparam logic [31:0]   ALERT_U   = 32'(ALERT_LVL);

    function automatic logic [N_ST-1:0] low_meters(input logic [N_ST*W-1:0] s);
        logic [N_ST-1:0] low;
        for (int i = 0; i < N_ST; i++) begin
            low[i] = (32'(s[i*W +: W]) < ALERT_U);
        end
        return low;
    endfunction

    function automatic logic any_empty(input logic [N_ST*W-1:0] s);
        logic z;
        z = 1'b0;
        for (int i = 0; i < N_ST; i++) begin
            z = z | (s[i*W +: W] == {W{1'b0}});
        end
        return z;
    endfunction

    estado_t         estado_q, estado_d;
    logic            tick_q, tick_d;
    logic [N_ST-1:0] alerta_q, alerta_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [AW-1:0]   act_q, act_d;
    logic            b1_l_q, b1_l_d, b2_l_q, b2_l_d;

    logic            both_hold_s, restart_s, eval_s, e1_s, e2_s, dead_s;
    logic [N_ST-1:0] low_s;
    logic [AW-1:0]   act_inc_s;

    // Next-state logic: soft restart outranks the tick evaluation.
    always_comb begin
        estado_d    = estado_q;
        tick_d      = 1'b0;
        alerta_d    = alerta_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        b1_l_d      = b1_l_q;
        b2_l_d      = b2_l_q;
        both_hold_s = b1_hold & b2_hold;
        restart_s   = both_hold_s && (hold_q == HOLD_FIRE);
        eval_s      = (cnt_q == CNT_LAST);
        e1_s        = b1_l_q | b1;
        e2_s        = b2_l_q | b2;
        low_s       = low_meters(status);
        dead_s      = any_empty(status);
        act_inc_s   = (act_q == ACT_MAX) ? act_q : act_q + AW'(1);

        if (!both_hold_s) begin
            hold_d = {HW{1'b0}};
        end else if (hold_q == HOLD_MAX) begin
            hold_d = hold_q;
        end else begin
            hold_d = hold_q + HW'(1);
        end

        if (restart_s) begin
            estado_d = INTRO;
            cnt_d    = {CW{1'b0}};
            act_d    = {AW{1'b0}};
            b1_l_d   = 1'b0;
            b2_l_d   = 1'b0;
        end else if (eval_s) begin
            cnt_d    = {CW{1'b0}};
            tick_d   = 1'b1;
            alerta_d = low_s;
            b1_l_d   = 1'b0;
            b2_l_d   = 1'b0;
            act_d    = {AW{1'b0}};
            if (estado_q == MORTO || dead_s) begin
                estado_d = MORTO;
            end else begin
                case (estado_q)
                    INTRO: begin
                        estado_d = (e1_s | e2_s) ? IDLE : INTRO;
                    end
                    IDLE, ALERTA: begin
                        if (e1_s && e2_s) begin
                            estado_d = DANDO_AULA;
                        end else if (e1_s) begin
                            estado_d = COMENDO;
                        end else if (e2_s) begin
                            estado_d = DORMINDO;
                        end else if (low_s != {N_ST{1'b0}}) begin
                            estado_d = ALERTA;
                        end else begin
                            estado_d = IDLE;
                        end
                    end
                    COMENDO, DORMINDO, DANDO_AULA: begin
                        if (e1_s || e2_s) begin
                            estado_d = IDLE;
                        end else if ((ACTION_TICKS > 0) && (act_inc_s == ACT_MAX)) begin
                            estado_d = IDLE;
                        end else begin
                            estado_d = estado_q;
                            act_d    = act_inc_s;
                        end
                    end
                    default: begin
                        estado_d = INTRO;
                    end
                endcase
            end
        end else begin
            cnt_d  = cnt_q + CW'(1);
            b1_l_d = b1_l_q | b1;
            b2_l_d = b2_l_q | b2;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= INTRO;
            tick_q   <= 1'b0;
            alerta_q <= {N_ST{1'b0}};
            cnt_q    <= {CW{1'b0}};
            hold_q   <= {HW{1'b0}};
            act_q    <= {AW{1'b0}};
            b1_l_q   <= 1'b0;
            b2_l_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            tick_q   <= tick_d;
            alerta_q <= alerta_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            act_q    <= act_d;
            b1_l_q   <= b1_l_d;
            b2_l_q   <= b2_l_d;
        end
    end

    assign estado = estado_q;
    assign tick   = tick_q;
    assign alerta = alerta_q;

endmodule
